// File: rtl/ysyx_22041211_pkg.sv
// Shared constants for the register file / scoreboard slice.
package ysyx_22041211_pkg;

   localparam int REG_ADDR_W         = 5;
   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_NUM_REGS   = 16;

endpackage

// File: rtl/ysyx_22041211_scoreboard.sv
// Per-register pending-write marks, RAW/WAW stall detection and a registered
// count of registers waiting on a writeback.
module ysyx_22041211_scoreboard
   import ysyx_22041211_pkg::*;
#(
   parameter int NUM_REGS = DEFAULT_NUM_REGS,
   parameter int IW       = $clog2(NUM_REGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [IW-1:0] rs1,
   input  logic          rs1_en,
   input  logic [IW-1:0] rs2,
   input  logic          rs2_en,
   input  logic          alloc_valid,
   input  logic [IW-1:0] alloc_rd,
   input  logic          wb_valid,
   input  logic [IW-1:0] wb_rd,
   input  logic          flush,
   output logic          stall,
   output logic [IW:0]   busy_cnt
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;
   logic [IW:0]         cnt_nxt;
   logic                raw1;
   logic                raw2;
   logic                waw;
   logic                alloc_ok;

   // A writeback landing this cycle resolves the hazard, so it masks the busy bit.
   always_comb begin
      raw1 = rs1_en && busy[rs1] && !(wb_valid && (wb_rd == rs1));
      raw2 = rs2_en && busy[rs2] && !(wb_valid && (wb_rd == rs2));
      waw  = alloc_valid && busy[alloc_rd] && !(wb_valid && (wb_rd == alloc_rd));
   end

   assign stall    = raw1 || raw2 || waw;
   assign alloc_ok = alloc_valid && !stall && !flush && (alloc_rd != '0);

   // Alloc is applied after wb so a same-register pair leaves the mark set.
   always_comb begin
      busy_nxt = busy;
      if (wb_valid) busy_nxt[wb_rd] = 1'b0;
      if (alloc_ok) busy_nxt[alloc_rd] = 1'b1;
      if (flush) busy_nxt = '0;
      busy_nxt[0] = 1'b0;
      cnt_nxt = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_nxt = cnt_nxt + {{IW{1'b0}}, busy_nxt[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/ysyx_22041211_regfile_sb.sv
// Register file with writeback bypass and an attached issue scoreboard.
module ysyx_22041211_regfile_sb
   import ysyx_22041211_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int NUM_REGS   = DEFAULT_NUM_REGS,
   parameter int IW         = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   input  logic                  rs1_en,
   input  logic                  rs2_en,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [DATA_WIDTH-1:0] rdata2,
   input  logic                  alloc_valid,
   input  logic [REG_ADDR_W-1:0] alloc_rd,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [DATA_WIDTH-1:0] wb_data,
   input  logic                  flush,
   output logic                  stall,
   output logic [IW:0]           busy_cnt
);

   logic [DATA_WIDTH-1:0] rf [NUM_REGS];
   logic [IW-1:0]         rs1_idx;
   logic [IW-1:0]         rs2_idx;
   logic [IW-1:0]         alloc_idx;
   logic [IW-1:0]         wb_idx;
   logic                  wb_we;

   // Upper address bits are ignored, so x21 aliases x5 with 16 registers.
   assign rs1_idx   = rs1[IW-1:0];
   assign rs2_idx   = rs2[IW-1:0];
   assign alloc_idx = alloc_rd[IW-1:0];
   assign wb_idx    = wb_rd[IW-1:0];
   assign wb_we     = wb_valid && (wb_idx != '0);

   generate
      if (IW < REG_ADDR_W) begin : g_unused
         logic unused_addr_bits;
         assign unused_addr_bits = ^{rs1[REG_ADDR_W-1:IW], rs2[REG_ADDR_W-1:IW],
                                     alloc_rd[REG_ADDR_W-1:IW], wb_rd[REG_ADDR_W-1:IW]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            rf[i] <= '0;
         end
      end else if (wb_we) begin
         rf[wb_idx] <= wb_data;
      end
   end

   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (rs1_idx != '0) rdata1 = (wb_we && (wb_idx == rs1_idx)) ? wb_data : rf[rs1_idx];
      if (rs2_idx != '0) rdata2 = (wb_we && (wb_idx == rs2_idx)) ? wb_data : rf[rs2_idx];
   end

   ysyx_22041211_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .IW       (IW)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .rs1         (rs1_idx),
      .rs1_en      (rs1_en),
      .rs2         (rs2_idx),
      .rs2_en      (rs2_en),
      .alloc_valid (alloc_valid),
      .alloc_rd    (alloc_idx),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_idx),
      .flush       (flush),
      .stall       (stall),
      .busy_cnt    (busy_cnt)
   );

endmodule
